// File: rtl/bg_render_pkg.sv
// Shared types and helpers for the background scroll renderer.
package bg_render_pkg;

  localparam int DEFAULT_IDX_W = 8;

  typedef struct packed {
    logic [3:0] red;
    logic [3:0] green;
    logic [3:0] blue;
  } rgb4_t;

  // Row-major texel address. With IMG_W a power of two, the shift-or is
  // the same as {ty, tx}: tx occupies the low tx_bits bits.
  function automatic logic [19:0] texel_addr(input logic [9:0] tx,
                                             input logic [9:0] ty,
                                             input int         tx_bits);
    return ({10'd0, ty} << tx_bits) | {10'd0, tx};
  endfunction

endpackage

// File: rtl/bg_delay_line.sv
// Fixed-depth shift register with synchronous active-low clear.
// A reset empties every stage, so nothing already in flight survives it.
module bg_delay_line
  import bg_render_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = 1
) (
  input  logic             vga_clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  // Shift din through DEPTH registers; clear all stages on reset.
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/bg_scroll_renderer.sv
// Full-screen scrolling background layer for the VGA path.
// Screen pixel -> texel address (power-of-two scale and wrap) -> external
// synchronous ROM -> external combinational palette -> registered RGB.
// Latency from DrawX/DrawY/blank to RGB is ROM_LATENCY+2 cycles.
// Optional: define BG_RENDER_TRANSPARENT_EN to add the TRANSPARENT_IDX
// parameter and the opaque output.
module bg_scroll_renderer
  import bg_render_pkg::*;
#(
  parameter int IMG_W       = 32,
  parameter int IMG_H       = 32,
  parameter int SCALE_LOG2  = 4,
  parameter int IDX_W       = DEFAULT_IDX_W,
  parameter int ROM_LATENCY = 1,
`ifdef BG_RENDER_TRANSPARENT_EN
  parameter int TRANSPARENT_IDX = 0,
`endif
  parameter int ADDR_W      = $clog2(IMG_W*IMG_H)
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  input  logic              frame_start,
  input  logic [9:0]        scroll_x,
  input  logic [9:0]        scroll_y,
  input  logic              auto_scroll,
  input  logic [3:0]        scroll_step,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [IDX_W-1:0]  rom_q,
  output logic [IDX_W-1:0]  pal_index,
  input  logic [3:0]        pal_red,
  input  logic [3:0]        pal_green,
  input  logic [3:0]        pal_blue,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic [9:0]        frame_x
`ifdef BG_RENDER_TRANSPARENT_EN
  ,
  output logic              opaque
`endif
);

  localparam int TX_W = $clog2(IMG_W);
  localparam int TY_W = $clog2(IMG_H);

  logic [9:0]      sy;
  logic [10:0]     ux;
  logic [10:0]     uy;
  logic [TX_W-1:0] tx;
  logic [TY_W-1:0] ty;
  logic            blank_d;
  logic            show;
  rgb4_t           pix;

  // Scroll offsets are sampled only on frame_start so a frame never tears.
  // Auto mode wraps at 1024 on purpose.
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      frame_x <= '0;
      sy      <= '0;
    end else if (frame_start) begin
      if (auto_scroll) frame_x <= frame_x + {6'd0, scroll_step};
      else             frame_x <= scroll_x;
      sy <= scroll_y;
    end
  end

  // Scrolled coordinates, scaled down and wrapped by bit truncation.
  always_comb begin
    ux = {1'b0, DrawX} + {1'b0, frame_x};
    uy = {1'b0, DrawY} + {1'b0, sy};
    tx = TX_W'(ux >> SCALE_LOG2);
    ty = TY_W'(uy >> SCALE_LOG2);
  end

  // Stage 0: register the texel address presented to the ROM.
  always_ff @(posedge vga_clk) begin
    if (!reset_n) rom_address <= '0;
    else          rom_address <= ADDR_W'(texel_addr(10'(tx), 10'(ty), TX_W));
  end

  assign pal_index = rom_q;

  // blank travels alongside the ROM access so it lines up with rom_q.
  bg_delay_line #(
    .DEPTH (ROM_LATENCY + 1),
    .WIDTH (1)
  ) u_blank_dly (
    .vga_clk (vga_clk),
    .reset_n (reset_n),
    .din     (blank),
    .dout    (blank_d)
  );

`ifdef BG_RENDER_TRANSPARENT_EN
  assign show = blank_d && (rom_q != IDX_W'(TRANSPARENT_IDX));
`else
  assign show = blank_d;
`endif

  // Output register: palette colour when visible, black otherwise.
  always_ff @(posedge vga_clk) begin
    if (!reset_n)  pix <= '0;
    else if (show) pix <= '{red: pal_red, green: pal_green, blue: pal_blue};
    else           pix <= '0;
  end

`ifdef BG_RENDER_TRANSPARENT_EN
  // Coverage flag for the colour mux, aligned with the RGB register.
  always_ff @(posedge vga_clk) begin
    if (!reset_n) opaque <= 1'b0;
    else          opaque <= show;
  end
`endif

  assign red   = pix.red;
  assign green = pix.green;
  assign blue  = pix.blue;

endmodule
